// File: rtl/rtc_modos_pkg.sv
// Shared definitions for the RTC mode sequencer and the global bus machine:
// state codes, one-hot enable words and the field codes.
package rtc_modos_pkg;

  typedef enum logic [1:0] {
    S_INI = 2'd0,
    S_LEE = 2'd1,
    S_ESC = 2'd2,
    S_GAP = 2'd3
  } estado_t;

  localparam logic [2:0] ENA_INI = 3'b100;
  localparam logic [2:0] ENA_LEE = 3'b010;
  localparam logic [2:0] ENA_ESC = 3'b001;
  localparam logic [2:0] ENA_GAP = 3'b000;

  // Field codes shared with maquinaglobal.
  localparam logic [3:0] seg   = 4'b0001;
  localparam logic [3:0] min   = 4'b0010;
  localparam logic [3:0] hora  = 4'b0011;
  localparam logic [3:0] dia   = 4'b0100;
  localparam logic [3:0] mes   = 4'b0101;
  localparam logic [3:0] anio  = 4'b0110;
  localparam logic [3:0] Thora = 4'b0111;
  localparam logic [3:0] Tmin  = 4'b1000;
  localparam logic [3:0] Tseg  = 4'b1001;

  function automatic logic [2:0] enables_de(input estado_t s);
    case (s)
      S_INI:   return ENA_INI;
      S_LEE:   return ENA_LEE;
      S_ESC:   return ENA_ESC;
      default: return ENA_GAP;
    endcase
  endfunction

  // Counter width able to hold 0..max-1 of the largest count, never below 1.
  function automatic int ancho_cnt(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/secuenciador_modo_antirrebote.sv
// Button conditioner: 2-FF synchroniser, stability counter, accepted level
// and a single-cycle pulse on the accepted level's rising edge.
module antirrebote
  import rtc_modos_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic raw_i,
  output logic nivel_o,
  output logic flanco_o
);

  localparam int CW = ancho_cnt(DEBOUNCE_CYCLES, 1, 1, 1);
  localparam logic [CW-1:0] CNT_FIN = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q, sync_d;
  logic          nivel_q, nivel_d;
  logic          flanco_q, flanco_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter only advances while the synchronised input disagrees with the
  // accepted level, so any agreeing sample restarts the stability window.
  always_comb begin
    sync_d  = {sync_q[0], raw_i};
    nivel_d = nivel_q;
    cnt_d   = '0;
    if (sync_q[1] != nivel_q) begin
      if (cnt_q == CNT_FIN) begin
        nivel_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    flanco_d = nivel_d & ~nivel_q;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync_q   <= '0;
      nivel_q  <= 1'b0;
      flanco_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= sync_d;
      nivel_q  <= nivel_d;
      flanco_q <= flanco_d;
      cnt_q    <= cnt_d;
    end
  end

  assign nivel_o  = nivel_q;
  assign flanco_o = flanco_q;

endmodule

// File: rtl/secuenciador_modo.sv
// Upstream mode sequencer for the RTC global machine: init, read and write
// enables separated by an all-low gap, plus the program commit pulse.
module secuenciador_modo
  import rtc_modos_pkg::*;
#(
  parameter int INI_CYCLES      = 10000,
  parameter int GAP_CYCLES      = 16,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int PULSE_CYCLES    = 7000000
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       btn_modo_i,
  input  logic       btn_prog_i,
  output logic [2:0] enables,
  output logic       pulsoprogramo_o,
  output logic [1:0] modo_o,
  output logic       ocupado_o
);

  localparam int CW = ancho_cnt(INI_CYCLES, GAP_CYCLES, DEBOUNCE_CYCLES, PULSE_CYCLES);
  localparam logic [CW-1:0] INI_FIN   = CW'(INI_CYCLES - 1);
  localparam logic [CW-1:0] GAP_FIN   = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] PULSO_FIN = CW'(PULSE_CYCLES - 1);

  // Index 0 is the mode button, index 1 the program button.
  logic [1:0] btn_raw;
  logic [1:0] niveles_unused;
  logic [1:0] eventos;

  assign btn_raw = {btn_prog_i, btn_modo_i};

  for (genvar gi = 0; gi < 2; gi++) begin : g_boton
    antirrebote #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_antirrebote (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .raw_i   (btn_raw[gi]),
      .nivel_o (niveles_unused[gi]),
      .flanco_o(eventos[gi])
    );
  end

  logic modo_ev, prog_ev;
  assign modo_ev = eventos[0];
  assign prog_ev = eventos[1];

  estado_t       state_q, state_d;
  estado_t       destino_q, destino_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulso_q, pulso_d;
  logic [CW-1:0] pcnt_q, pcnt_d;
  logic [2:0]    enables_q, enables_d;
  logic          ocupado_q, ocupado_d;

  always_comb begin
    state_d   = state_q;
    destino_d = destino_q;
    cnt_d     = '0;
    pulso_d   = 1'b0;
    pcnt_d    = '0;
    case (state_q)
      S_INI: begin
        if (cnt_q == INI_FIN) begin
          state_d   = S_GAP;
          destino_d = S_LEE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_FIN) begin
          state_d = destino_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_LEE: begin
        if (modo_ev) begin
          destino_d = S_ESC;
          state_d   = S_GAP;
        end
      end
      S_ESC: begin
        // A running pulse locks out both buttons; program beats mode when
        // both arrive together.
        if (pulso_q) begin
          if (pcnt_q != PULSO_FIN) begin
            pulso_d = 1'b1;
            pcnt_d  = pcnt_q + 1'b1;
          end
        end else if (prog_ev) begin
          pulso_d = 1'b1;
        end else if (modo_ev) begin
          destino_d = S_LEE;
          state_d   = S_GAP;
        end
      end
      default: state_d = S_INI;
    endcase
    enables_d = enables_de(state_d);
    ocupado_d = (state_d == S_INI) || (state_d == S_GAP) || pulso_d;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= S_INI;
      destino_q <= S_INI;
      cnt_q     <= '0;
      pulso_q   <= 1'b0;
      pcnt_q    <= '0;
      enables_q <= ENA_INI;
      ocupado_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      destino_q <= destino_d;
      cnt_q     <= cnt_d;
      pulso_q   <= pulso_d;
      pcnt_q    <= pcnt_d;
      enables_q <= enables_d;
      ocupado_q <= ocupado_d;
    end
  end

  assign enables         = enables_q;
  assign pulsoprogramo_o = pulso_q;
  assign modo_o          = state_q;
  assign ocupado_o       = ocupado_q;

endmodule
